// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and ALU sequencer with valid/ready command and response streams
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command stream handshake
//   cmd_op, cmd_chain            opcode (7 reserved); chain selects the ALU accumulator as operand A
//   cmd_a, cmd_b                 operands
//   alu_in_selector              {persist, load, reset}; 000 holds the ALU
//   alu_num1, alu_num2           operands driven to the ALU
//   alu_out_selector             one-hot operation select
//   alu_result, alu_error        ALU result and overflow flag
//   rsp_valid/rsp_ready          response stream handshake
//   rsp_data, rsp_err            captured result and error flag
//   rsp_illegal                  command rejected without touching the ALU
//   busy                         sequencer active or commands queued
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_chain,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       alu_in_selector,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_selector,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_illegal,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int EW = 3 + 1 + 2 * WIDTH;

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [EW-1:0] fifo_mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [EW-1:0] head;
    logic [2:0]    head_op;
    logic          head_chain;

    // Command being executed.
    logic [2:0]       op_q, op_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             acc_valid_q, acc_valid_d;
    logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic [2:0]       in_sel_c;
    logic [WIDTH-1:0] num1_c, num2_c;
    logic [6:0]       out_sel_c;
    logic             rsp_valid_c;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full blocks a push even when the same cycle pops; keeps cmd_ready free of FSM timing.
    assign cmd_ready  = !fifo_full && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !rst;

    assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign head_op    = head[EW-1 -: 3];
    assign head_chain = head[2*WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_chain, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= '0;
            chain_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc_valid_q   <= 1'b0;
            wait_cnt_q    <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            op_q          <= op_d;
            chain_q       <= chain_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_valid_q   <= acc_valid_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        chain_d       = chain_q;
        a_d           = a_q;
        b_d           = b_q;
        acc_valid_d   = acc_valid_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        rsp_illegal_d = rsp_illegal_q;
        in_sel_c      = 3'b000;
        num1_c        = '0;
        num2_c        = '0;
        out_sel_c     = '0;
        rsp_valid_c   = 1'b0;

        case (state_q)
            S_CLR: begin
                in_sel_c    = 3'b001;
                acc_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    {op_d, chain_d, a_d, b_d} = head;
                    wait_cnt_d = '0;
                    // A chained op needs a trustworthy accumulator; reserved ops never reach the ALU.
                    if (head_op == 3'd7 || (head_chain && !acc_valid_q)) begin
                        rsp_data_d    = '0;
                        rsp_err_d     = 1'b0;
                        rsp_illegal_d = 1'b1;
                        state_d       = S_RESP;
                    end else begin
                        rsp_illegal_d = 1'b0;
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                in_sel_c  = chain_q ? 3'b100 : 3'b010;
                num1_c    = chain_q ? '0 : a_q;
                num2_c    = b_q;
                out_sel_c = 7'b1 << op_q;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                num1_c    = chain_q ? '0 : a_q;
                num2_c    = b_q;
                out_sel_c = 7'b1 << op_q;
                if (wait_cnt_q == CW'(LAT - 1)) begin
                    rsp_data_d  = alu_result;
                    rsp_err_d   = alu_error;
                    acc_valid_d = !alu_error;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) begin
                    // An overflowed accumulator is cleared before anything else runs.
                    state_d = rsp_err_q ? S_CLR : S_IDLE;
                end
            end
            default: begin
                state_d = S_CLR;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign alu_in_selector  = rst ? 3'b000 : in_sel_c;
    assign alu_num1         = rst ? '0 : num1_c;
    assign alu_num2         = rst ? '0 : num2_c;
    assign alu_out_selector = rst ? '0 : out_sel_c;
    assign rsp_valid        = rst ? 1'b0 : rsp_valid_c;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_illegal      = rsp_illegal_q;
    assign busy             = !rst && ((state_q != S_IDLE) || !fifo_empty);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic             cmd_chain = 1'b0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [2:0]       alu_in_selector;
    logic [WIDTH-1:0] alu_num1, alu_num2;
    logic [6:0]       alu_out_selector;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_error = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err, rsp_illegal, busy;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_selector(alu_in_selector), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_selector(alu_out_selector), .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Operation arithmetic: returns {overflow, result[7:0]}.
    function automatic logic [8:0] arith(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        case (op)
            3'd0: r = {8'd0, a & b};
            3'd1: r = {8'd0, a | b};
            3'd2: r = {8'd0, ~a};
            3'd3: r = {8'd0, a ^ b};
            3'd4: begin r = {8'd0, a} + {8'd0, b}; e = r[8]; end
            3'd5: begin r = {8'd0, a} - {8'd0, b}; e = (a < b); end
            3'd6: begin r = {8'd0, a} * {8'd0, b}; e = |r[15:8]; end
            default: begin r = '0; e = 1'b1; end
        endcase
        return {e, r[7:0]};
    endfunction

    function automatic logic [2:0] onehot_op(input logic [6:0] sel);
        logic [2:0] op;
        op = 3'd7;
        for (int i = 0; i < 7; i++) begin
            if (sel == (7'b1 << i)) op = 3'(i);
        end
        return op;
    endfunction

    // ALU stand-in: registered result, one cycle after the load/persist cycle.
    logic [7:0] alu_acc = '0;
    logic [8:0] alu_calc;
    int         issue_cnt = 0;
    assign alu_calc = arith(onehot_op(alu_out_selector),
                            (alu_in_selector == 3'b010) ? alu_num1 : alu_acc, alu_num2);

    always @(posedge clk) begin
        if (alu_in_selector == 3'b001) begin
            alu_acc <= '0;
        end else if (alu_in_selector == 3'b010 || alu_in_selector == 3'b100) begin
            alu_result <= alu_calc[7:0];
            alu_error  <= alu_calc[8];
            alu_acc    <= alu_calc[7:0];
            issue_cnt  <= issue_cnt + 1;
        end
    end

    // Reference model: accepted commands in order, accumulator validity tracked from results.
    typedef struct packed {
        logic [2:0] op;
        logic       chain;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t       exp_q[$];
    logic       m_acc_valid = 1'b0;
    logic [7:0] m_acc = '0;
    int         rsp_cnt = 0;
    logic [7:0] last_data = '0;
    logic       last_err = 1'b0;
    logic       last_ill = 1'b0;
    logic       hold_valid = 1'b0;
    logic [9:0] hold_val = '0;

    always @(negedge clk) begin
        cmd_t       c;
        logic [8:0] r;
        logic [7:0] e_data;
        logic       e_err, e_ill;
        if (rst) begin
            exp_q.delete();
            m_acc_valid = 1'b0;
            hold_valid  = 1'b0;
        end else begin
            if (hold_valid && !rsp_valid) begin
                expect_eq("rsp_dropped", {31'd0, rsp_valid}, 32'd1);
                hold_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (hold_valid) begin
                    expect_eq("rsp_stable", {22'd0, rsp_data, rsp_err, rsp_illegal}, {22'd0, hold_val});
                end
                if (rsp_ready) begin
                    hold_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        expect_eq("rsp_unexpected", exp_q.size(), 32'd1);
                    end else begin
                        c = exp_q.pop_front();
                        if (c.op == 3'd7 || (c.chain && !m_acc_valid)) begin
                            e_data = '0; e_err = 1'b0; e_ill = 1'b1;
                        end else begin
                            r = arith(c.op, c.chain ? m_acc : c.a, c.b);
                            e_data = r[7:0]; e_err = r[8]; e_ill = 1'b0;
                            m_acc = r[7:0];
                            m_acc_valid = !r[8];
                        end
                        expect_eq("rsp_data", {24'd0, rsp_data}, {24'd0, e_data});
                        expect_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
                        expect_eq("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e_ill});
                        rsp_cnt++;
                        last_data = rsp_data;
                        last_err  = rsp_err;
                        last_ill  = rsp_illegal;
                    end
                end else begin
                    hold_valid = 1'b1;
                    hold_val   = {rsp_data, rsp_err, rsp_illegal};
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{op: cmd_op, chain: cmd_chain, a: cmd_a, b: cmd_b});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command and wait (bounded) until it is accepted.
    task automatic send(input logic [2:0] op, input logic chain, input logic [7:0] a, input logic [7:0] b);
        int k;
        cmd_op = op; cmd_chain = chain; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1;
        for (k = 0; k < 50 && !cmd_ready; k++) step();
        if (!cmd_ready) expect_eq("send_timeout", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue();
        int k;
        for (k = 0; k < 30 && !(alu_in_selector == 3'b010 || alu_in_selector == 3'b100); k++) step();
        if (k == 30) expect_eq("issue_timeout", {29'd0, alu_in_selector}, 32'd2);
    endtask

    task automatic wait_rsp();
        int k;
        for (k = 0; k < 30 && !rsp_valid; k++) step();
        if (k == 30) expect_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300 && !(exp_q.size() == 0 && !busy && !rsp_valid); k++) step();
        expect_eq("drain", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        int base_rsp, base_issue;
        rst = 1'b1;
        repeat (3) step();
        expect_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        expect_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        expect_eq("rst_busy", {31'd0, busy}, 32'd0);
        expect_eq("rst_in_sel", {29'd0, alu_in_selector}, 32'd0);

        // Reset release: one S_CLR cycle then idle.
        rst = 1'b0;
        #1;
        expect_eq("clr_in_sel", {29'd0, alu_in_selector}, 32'd1);
        step();
        expect_eq("idle_in_sel", {29'd0, alu_in_selector}, 32'd0);
        expect_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        expect_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Non-chained add with exact latency.
        rsp_ready = 1'b1;
        send(3'd4, 1'b0, 8'h0F, 8'h01);
        step();
        expect_eq("add_issue_in_sel", {29'd0, alu_in_selector}, 32'd2);
        expect_eq("add_issue_out_sel", {25'd0, alu_out_selector}, 32'h10);
        expect_eq("add_issue_num1", {24'd0, alu_num1}, 32'h0F);
        expect_eq("add_issue_num2", {24'd0, alu_num2}, 32'h01);
        step();
        expect_eq("add_wait_in_sel", {29'd0, alu_in_selector}, 32'd0);
        expect_eq("add_wait_out_sel", {25'd0, alu_out_selector}, 32'h10);
        expect_eq("add_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        expect_eq("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        expect_eq("add_rsp_data", {24'd0, rsp_data}, 32'h10);
        expect_eq("add_rsp_err", {31'd0, rsp_err}, 32'd0);
        step();
        expect_eq("add_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        wait_drain();

        // Chain: 3+4 then accumulator*2.
        send(3'd4, 1'b0, 8'h03, 8'h04);
        send(3'd6, 1'b1, 8'h55, 8'h02);
        wait_issue();
        expect_eq("chain1_in_sel", {29'd0, alu_in_selector}, 32'd2);
        step();
        wait_issue();
        expect_eq("chain2_in_sel", {29'd0, alu_in_selector}, 32'd4);
        expect_eq("chain2_num1", {24'd0, alu_num1}, 32'd0);
        expect_eq("chain2_out_sel", {25'd0, alu_out_selector}, 32'h40);
        wait_drain();
        expect_eq("chain_last", {24'd0, last_data}, 32'h0E);

        // Overflow recovery, chained-after-error and reserved op.
        send(3'd6, 1'b0, 8'h20, 8'h10);
        wait_rsp();
        expect_eq("ovf_rsp_err", {31'd0, rsp_err}, 32'd1);
        step();
        expect_eq("ovf_clr_in_sel", {29'd0, alu_in_selector}, 32'd1);
        wait_drain();
        base_issue = issue_cnt;
        send(3'd4, 1'b1, 8'h05, 8'h05);
        wait_drain();
        expect_eq("ill_chain_flag", {31'd0, last_ill}, 32'd1);
        expect_eq("ill_chain_data", {24'd0, last_data}, 32'd0);
        expect_eq("ill_chain_no_issue", issue_cnt, base_issue);
        send(3'd7, 1'b0, 8'h01, 8'h02);
        wait_drain();
        expect_eq("ill_op7_flag", {31'd0, last_ill}, 32'd1);
        expect_eq("ill_op7_no_issue", issue_cnt, base_issue);

        // Backpressure: one response stalled, FIFO filled, fifth command waits for a pop.
        base_rsp = rsp_cnt;
        rsp_ready = 1'b0;
        send(3'd1, 1'b0, 8'hA5, 8'h0F);
        wait_rsp();
        for (int i = 0; i < 4; i++) send(3'(i), 1'b0, 8'(8'h10 + i), 8'h33);
        expect_eq("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
        expect_eq("bp_busy", {31'd0, busy}, 32'd1);
        cmd_op = 3'd3; cmd_chain = 1'b0; cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_valid = 1'b1;
        repeat (5) step();
        expect_eq("bp_still_full", {31'd0, cmd_ready}, 32'd0);
        expect_eq("bp_queue_len", exp_q.size(), 32'd5);
        rsp_ready = 1'b1;
        send(3'd3, 1'b0, 8'hF0, 8'h0F);
        wait_drain();
        expect_eq("bp_rsp_count", rsp_cnt - base_rsp, 32'd6);

        // Reset during S_WAIT discards the operation.
        base_rsp = rsp_cnt;
        send(3'd4, 1'b0, 8'h09, 8'h09);
        step();
        step();
        expect_eq("rstw_wait_out_sel", {25'd0, alu_out_selector}, 32'h10);
        rst = 1'b1;
        step();
        expect_eq("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        expect_eq("rstw_clr_in_sel", {29'd0, alu_in_selector}, 32'd1);
        expect_eq("rstw_clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        expect_eq("rstw_idle_busy", {31'd0, busy}, 32'd0);
        expect_eq("rstw_no_rsp", rsp_cnt, base_rsp);
        send(3'd4, 1'b0, 8'h01, 8'h01);
        wait_drain();
        expect_eq("rstw_after_add", {24'd0, last_data}, 32'h02);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_chain = 1'($urandom_range(0, 1));
            cmd_a     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            cmd_b     = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        cmd_valid = 1'b0;
        rst = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
